// File: rtl/audio_frame_sequencer.sv
// -----------------------------------------------------------------------------
// audio_frame_sequencer
//   Builds 18-bit audio samples from 3-byte UART frames, queues them in a small
//   FIFO and plays one sample to the DAC per sample-rate tick.
//
//   Frame layout: byte0 = sample[7:0], byte1 = sample[15:8],
//                 byte2 = sample[17:16] in bits [1:0]; bits [7:2] must be zero.
//
// Ports:
//   CLK_IN        sole clock, rising edge
//   RST_IN        asynchronous active-high reset
//   RX_DATA_i     received UART byte
//   RX_VALID_i    one-cycle strobe qualifying RX_DATA_i
//   DAC_READY_i   DAC can accept a load this cycle
//   DAC_DATA_o    current DAC sample (held between loads)
//   DAC_LOAD_o    one-cycle load strobe
//   FIFO_LEVEL_o  number of stored samples (0..FIFO_DEPTH)
//   FRAME_ERR_o   one-cycle pulse when a frame is discarded
//   UNDERRUN_o    sticky: a tick found the FIFO empty
//   OVERRUN_o     sticky: a complete frame was dropped on a full FIFO
//
// Build option:
//   SEQ_TIMEOUT_EN  when defined, a gap of TIMEOUT_CYCLES cycles inside a frame
//                   abandons the partial frame and pulses FRAME_ERR_o.
// -----------------------------------------------------------------------------
module audio_frame_sequencer #(
   parameter int CLK_FREQ       = 12_000_000,
   parameter int SAMPLE_RATE    = 44_100,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        CLK_IN,
   input  logic        RST_IN,
   input  logic [7:0]  RX_DATA_i,
   input  logic        RX_VALID_i,
   input  logic        DAC_READY_i,
   output logic [17:0] DAC_DATA_o,
   output logic        DAC_LOAD_o,
   output logic [4:0]  FIFO_LEVEL_o,
   output logic        FRAME_ERR_o,
   output logic        UNDERRUN_o,
   output logic        OVERRUN_o
);

   localparam int DIV = CLK_FREQ / SAMPLE_RATE;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       TIMEOUT_CYCLES < 1 || DIV < 1) begin : g_bad_param
      $error("audio_frame_sequencer: illegal parameter set");
   end

   typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} state_e;

   state_e      state_q, state_d;
   logic [7:0]  b0_q, b0_d, b1_q, b1_d;
   logic        push_q, push_d;
   logic [17:0] push_data_q, push_data_d;
   logic        ferr_q, ferr_d;
   logic        tmo;

   // ---------------- inter-byte gap timeout ----------------
`ifdef SEQ_TIMEOUT_EN
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
   logic [GW-1:0] gap_q;

   // gap_q counts idle cycles since the last byte while a frame is open
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN)                           gap_q <= '0;
      else if (RX_VALID_i || state_q == BYTE0) gap_q <= '0;
      else                                  gap_q <= gap_q + 1'b1;
   end

   // fires on the TIMEOUT_CYCLES-th consecutive idle cycle
   assign tmo = (state_q != BYTE0) && !RX_VALID_i && (gap_q == GW'(TIMEOUT_CYCLES - 1));
`else
   assign tmo = 1'b0;
`endif

   // ---------------- frame assembler ----------------
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         state_q     <= BYTE0;
         b0_q        <= '0;
         b1_q        <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         ferr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         ferr_q      <= ferr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      ferr_d      = 1'b0;
      if (RX_VALID_i) begin
         case (state_q)
            BYTE0: begin b0_d = RX_DATA_i; state_d = BYTE1; end
            BYTE1: begin b1_d = RX_DATA_i; state_d = BYTE2; end
            BYTE2: begin
               state_d = BYTE0;
               if (RX_DATA_i[7:2] != 6'd0) ferr_d = 1'b1;
               else begin
                  push_d      = 1'b1;
                  push_data_d = {RX_DATA_i[1:0], b1_q, b0_q};
               end
            end
            default: state_d = BYTE0;
         endcase
      end else if (tmo) begin
         state_d = BYTE0;
         ferr_d  = 1'b1;
      end
   end

   // ---------------- tick, FIFO and DAC side ----------------
   logic [CW-1:0] cnt_q;
   logic [AW-1:0] wr_q, rd_q;
   logic [4:0]    level_q;
   logic [17:0]   mem_q [FIFO_DEPTH];
   logic          tick, pop, push_ok;

   assign tick = (cnt_q == CW'(DIV - 1));
   // pop decision uses the pre-push level, so a sample is never popped in its push cycle
   assign pop     = tick && DAC_READY_i && (level_q != 5'd0);
   assign push_ok = push_q && ((level_q != 5'(FIFO_DEPTH)) || pop);

   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         cnt_q      <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         level_q    <= '0;
         DAC_DATA_o <= '0;
         DAC_LOAD_o <= 1'b0;
         UNDERRUN_o <= 1'b0;
         OVERRUN_o  <= 1'b0;
      end else begin
         cnt_q      <= tick ? '0 : cnt_q + 1'b1;
         DAC_LOAD_o <= pop;
         if (pop) begin
            DAC_DATA_o <= mem_q[rd_q];
            rd_q       <= rd_q + 1'b1;
         end
         if (push_ok)             wr_q       <= wr_q + 1'b1;
         if (push_q && !push_ok)  OVERRUN_o  <= 1'b1;
         if (tick && DAC_READY_i && level_q == 5'd0) UNDERRUN_o <= 1'b1;
         case ({push_ok, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // sample storage needs no reset; pointers define what is valid
   always_ff @(posedge CLK_IN) begin
      if (push_ok) mem_q[wr_q] <= push_data_q;
   end

   assign FIFO_LEVEL_o = level_q;
   assign FRAME_ERR_o  = ferr_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_audio_frame_sequencer
//   Self-checking bench for audio_frame_sequencer at default parameters.
//   Played samples and error pulses are collected by a monitor; each scenario
//   task compares them against expectations derived from the frame rules.
// -----------------------------------------------------------------------------
module tb_audio_frame_sequencer;

   localparam int DIV   = 12_000_000 / 44_100;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        dac_ready = 1'b0;
   logic [17:0] dac_data;
   logic        dac_load;
   logic [4:0]  level;
   logic        frame_err;
   logic        underrun;
   logic        overrun;

   int checks = 0;
   int fails  = 0;

   audio_frame_sequencer dut (
      .CLK_IN      (clk),
      .RST_IN      (rst),
      .RX_DATA_i   (rx_data),
      .RX_VALID_i  (rx_valid),
      .DAC_READY_i (dac_ready),
      .DAC_DATA_o  (dac_data),
      .DAC_LOAD_o  (dac_load),
      .FIFO_LEVEL_o(level),
      .FRAME_ERR_o (frame_err),
      .UNDERRUN_o  (underrun),
      .OVERRUN_o   (overrun)
   );

   always #5 clk = ~clk;

   // ---------------- monitor ----------------
   int          cyc = 0;
   logic [17:0] obs_v [$];
   int          obs_t [$];
   int          err_cnt = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst && dac_load) begin
         obs_v.push_back(dac_data);
         obs_t.push_back(cyc);
      end
      if (!rst && frame_err) err_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      rst = 1'b1; rx_valid = 1'b0; dac_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send_byte(a); send_byte(b); send_byte(c);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_loads(input int target, input int budget);
      int k = 0;
      while (obs_v.size() < target && k < budget) begin
         @(negedge clk); #1; k++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (dac_data !== 18'd0) begin fails++; $display("FAIL reset_data: got %h want 0", dac_data); end
      checks++; if (dac_load !== 1'b0)  begin fails++; $display("FAIL reset_load: got %b want 0", dac_load); end
      checks++; if (level !== 5'd0)     begin fails++; $display("FAIL reset_level: got %0d want 0", level); end
      checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
      checks++; if (underrun !== 1'b0)  begin fails++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      checks++; if (overrun !== 1'b0)   begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      // ticks with DAC not ready must not flag underrun
      idle(DIV + 30);
      checks++; if (underrun !== 1'b0)  begin fails++; $display("FAIL notready_underrun: got %b want 0", underrun); end
   endtask

   task automatic test_single();
      int base;
      do_reset();
      base = obs_v.size();
      send_frame(8'hB8, 8'h01, 8'h00);
      idle(3);
      checks++; if (level !== 5'd1) begin fails++; $display("FAIL single_level: got %0d want 1", level); end
      dac_ready = 1'b1;
      wait_loads(base + 1, 2 * DIV);
      checks++;
      if (obs_v.size() != base + 1) begin fails++; $display("FAIL single_load_count: got %0d want 1", obs_v.size() - base); end
      else if (obs_v[base] !== 18'h001B8) begin fails++; $display("FAIL single_value: got %h want 001b8", obs_v[base]); end
      checks++; if (level !== 5'd0) begin fails++; $display("FAIL single_level_after: got %0d want 0", level); end
   endtask

   task automatic test_back_to_back();
      int base;
      logic [17:0] exp [3];
      exp[0] = 18'h105; exp[1] = 18'h125; exp[2] = 18'h149;
      do_reset();
      base = obs_v.size();
      send_frame(8'h05, 8'h01, 8'h00);
      send_frame(8'h25, 8'h01, 8'h00);
      send_frame(8'h49, 8'h01, 8'h00);
      idle(3);
      dac_ready = 1'b1;
      wait_loads(base + 3, 4 * DIV);
      checks++;
      if (obs_v.size() < base + 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", obs_v.size() - base); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_v[base+i] !== exp[i]) begin fails++; $display("FAIL b2b_value%0d: got %h want %h", i, obs_v[base+i], exp[i]); end
         end
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (obs_t[base+i] - obs_t[base+i-1] != DIV) begin
               fails++; $display("FAIL b2b_spacing%0d: got %0d want %0d", i, obs_t[base+i] - obs_t[base+i-1], DIV);
            end
         end
      end
   endtask

   task automatic test_overrun();
      int base;
      do_reset();
      base = obs_v.size();
      for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 8'h02, 8'h01);
      idle(3);
      checks++; if (level !== 5'(DEPTH)) begin fails++; $display("FAIL ovr_level: got %0d want %0d", level, DEPTH); end
      checks++; if (overrun !== 1'b1)    begin fails++; $display("FAIL ovr_flag: got %b want 1", overrun); end
      dac_ready = 1'b1;
      wait_loads(base + DEPTH, (DEPTH + 2) * DIV);
      checks++;
      if (obs_v.size() != base + DEPTH) begin fails++; $display("FAIL ovr_count: got %0d want %0d", obs_v.size() - base, DEPTH); end
      else for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (obs_v[base+i] !== {2'b01, 8'h02, 8'(8'h10 + i)}) begin
            fails++; $display("FAIL ovr_value%0d: got %h want %h", i, obs_v[base+i], {2'b01, 8'h02, 8'(8'h10 + i)});
         end
      end
      idle(DIV + 5);
      checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_frame_err_underrun();
      int base, e0;
      do_reset();
      base = obs_v.size();
      e0 = err_cnt;
      send_frame(8'h5D, 8'h01, 8'h04);
      idle(3);
      checks++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL ferr_pulse: got %0d want 1", err_cnt - e0); end
      checks++; if (level !== 5'd0)    begin fails++; $display("FAIL ferr_level: got %0d want 0", level); end
      send_frame(8'h5D, 8'h01, 8'h00);
      idle(3);
      checks++; if (level !== 5'd1)    begin fails++; $display("FAIL ferr_level2: got %0d want 1", level); end
      dac_ready = 1'b1;
      wait_loads(base + 1, 2 * DIV);
      checks++;
      if (obs_v.size() != base + 1) begin fails++; $display("FAIL ferr_load_count: got %0d want 1", obs_v.size() - base); end
      else if (obs_v[base] !== 18'h15D) begin fails++; $display("FAIL ferr_value: got %h want 15d", obs_v[base]); end
      checks++; if (underrun !== 1'b0) begin fails++; $display("FAIL underrun_early: got %b want 0", underrun); end
      idle(DIV + 10);
      checks++; if (underrun !== 1'b1)     begin fails++; $display("FAIL underrun_flag: got %b want 1", underrun); end
      checks++; if (dac_data !== 18'h15D)  begin fails++; $display("FAIL underrun_hold: got %h want 15d", dac_data); end
      checks++; if (obs_v.size() != base + 1) begin fails++; $display("FAIL underrun_noload: got %0d loads want 1", obs_v.size() - base); end
   endtask

   task automatic test_gap();
      int base, e0;
      do_reset();
      base = obs_v.size();
      e0 = err_cnt;
      send_byte(8'h87); send_byte(8'h01);
      idle(5000);
`ifdef SEQ_TIMEOUT_EN
      checks++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL timeout_pulse: got %0d want 1", err_cnt - e0); end
      send_frame(8'h87, 8'h01, 8'h00);
`else
      checks++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL gap_no_pulse: got %0d want 0", err_cnt - e0); end
      send_byte(8'h00);   // the partial frame survives the gap
`endif
      idle(3);
      checks++; if (level !== 5'd1) begin fails++; $display("FAIL gap_level: got %0d want 1", level); end
      dac_ready = 1'b1;
      wait_loads(base + 1, 2 * DIV);
      checks++;
      if (obs_v.size() != base + 1) begin fails++; $display("FAIL gap_load_count: got %0d want 1", obs_v.size() - base); end
      else if (obs_v[base] !== 18'h187) begin fails++; $display("FAIL gap_value: got %h want 187", obs_v[base]); end
   endtask

   task automatic test_reset_mid();
      int base, k;
      do_reset();
      send_byte(8'h11); send_byte(8'h22);
      rst = 1'b1; idle(2); rst = 1'b0;
      base = obs_v.size();
      send_frame(8'h33, 8'h44, 8'h00);
      idle(3);
      checks++; if (level !== 5'd1) begin fails++; $display("FAIL midframe_level: got %0d want 1", level); end
      dac_ready = 1'b1;
      wait_loads(base + 1, 2 * DIV);
      checks++;
      if (obs_v.size() != base + 1) begin fails++; $display("FAIL midframe_count: got %0d want 1", obs_v.size() - base); end
      else if (obs_v[base] !== 18'h04433) begin fails++; $display("FAIL midframe_value: got %h want 04433", obs_v[base]); end
      // reset landing on an active load strobe
      send_frame(8'hAA, 8'h55, 8'h03);
      k = 0;
      while (k < 2 * DIV) begin
         @(posedge clk); #1; k++;
         if (dac_load) break;
      end
      checks++;
      if (!dac_load) begin fails++; $display("FAIL midload_seen: got no load within %0d cycles", 2 * DIV); end
      else begin
         rst = 1'b1; #1;
         checks++; if (dac_load !== 1'b0)  begin fails++; $display("FAIL midload_cancel: got %b want 0", dac_load); end
         checks++; if (dac_data !== 18'd0) begin fails++; $display("FAIL midload_data: got %h want 0", dac_data); end
      end
      idle(2); rst = 1'b0; dac_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [17:0] exp [$];
      int base, e0, bad, k;
      logic [7:0] b0, b1, b2;
      do_reset();
      base = obs_v.size();
      e0 = err_cnt;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         b0 = 8'($urandom); b1 = 8'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            b2 = {6'($urandom_range(1, 63)), 2'($urandom)};
            bad++;
         end else begin
            b2 = {6'd0, 2'($urandom)};
            exp.push_back({b2[1:0], b1, b0});
            k = 0;
            while (level >= 5'd6 && k < 4 * DIV) begin
               dac_ready = 1'b1; @(negedge clk); k++;
            end
         end
         dac_ready = 1'($urandom);
         send_byte(b0); idle($urandom_range(0, 3));
         dac_ready = 1'($urandom);
         send_byte(b1); idle($urandom_range(0, 3));
         send_byte(b2);
      end
      dac_ready = 1'b1;
      wait_loads(base + exp.size(), (exp.size() + 4) * DIV);
      checks++;
      if (obs_v.size() != base + exp.size()) begin
         fails++; $display("FAIL rand_count: got %0d want %0d", obs_v.size() - base, exp.size());
      end else for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (obs_v[base+i] !== exp[i]) begin fails++; $display("FAIL rand_value%0d: got %h want %h", i, obs_v[base+i], exp[i]); end
      end
      checks++; if (err_cnt - e0 != bad) begin fails++; $display("FAIL rand_errs: got %0d want %0d", err_cnt - e0, bad); end
      checks++; if (overrun !== 1'b0)    begin fails++; $display("FAIL rand_overrun: got %b want 0", overrun); end
      checks++; if (level !== 5'd0)      begin fails++; $display("FAIL rand_level: got %0d want 0", level); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_frame_err_underrun();
      test_gap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/audio_frame_sequencer.md
AUDIO_FRAME_SEQUENCER -- requirements
Module: audio_frame_sequencer

Interface
REQ-001 Parameter CLK_FREQ, default 12_000_000: CLK_IN frequency in Hz.
REQ-002 Parameter SAMPLE_RATE, default 44_100: DAC update rate in Hz; DIV = CLK_FREQ/SAMPLE_RATE, integer-truncated (272 at defaults).
REQ-003 Parameter FIFO_DEPTH, default 8: sample FIFO entries, power of two, 2..16.
REQ-004 Parameter TIMEOUT_CYCLES, default 4096: maximum inter-byte gap inside a frame, in CLK_IN cycles.
REQ-005 CLK_IN  input  1  sole clock; all state changes on its rising edge.
REQ-006 RST_IN  input  1  reset, asynchronous, active-high.
REQ-007 RX_DATA_i  input  8  received UART byte.
REQ-008 RX_VALID_i  input  1  one-cycle strobe qualifying RX_DATA_i.
REQ-009 DAC_READY_i  input  1  DAC can accept a load this cycle.
REQ-010 DAC_DATA_o  output  18  current DAC sample.
REQ-011 DAC_LOAD_o  output  1  one-cycle load strobe to the DAC.
REQ-012 FIFO_LEVEL_o  output  5  number of stored samples.
REQ-013 FRAME_ERR_o  output  1  one-cycle pulse on a discarded frame.
REQ-014 UNDERRUN_o  output  1  sticky: a tick found no sample to play.
REQ-015 OVERRUN_o  output  1  sticky: a complete frame was dropped because the FIFO was full.

Function
REQ-016 Assembler FSM states: BYTE0, BYTE1, BYTE2; each RX_VALID_i advances BYTE0->BYTE1->BYTE2->BYTE0.
REQ-017 Byte order: BYTE0 = sample[7:0], BYTE1 = sample[15:8], BYTE2 = sample[17:16] in bits [1:0].
REQ-018 If the BYTE2 byte has bits [7:2] nonzero, the frame is discarded, FRAME_ERR_o pulses the next cycle, and the FSM returns to BYTE0.
REQ-019 A valid frame is pushed on the cycle after its BYTE2 strobe; it is accepted if the FIFO is not full or a pop occurs in the same cycle.
REQ-020 Otherwise the frame is dropped and OVERRUN_o is set.
REQ-021 Tick counter counts 0..DIV-1 and wraps to 0; a tick is generated when count == DIV-1.
REQ-022 Tick with FIFO non-empty and DAC_READY_i high: pop; DAC_DATA_o takes the head sample and DAC_LOAD_o is high for exactly one cycle, both registered one cycle after the tick.
REQ-023 Tick with FIFO empty: no load, DAC_DATA_o holds its value, UNDERRUN_o is set.
REQ-024 Tick with DAC_READY_i low: no pop, no load, no flag change; the sample waits for the next tick.
REQ-025 Simultaneous push and pop: the level is unchanged, FIFO order is preserved, and a pushed sample is never popped in its push cycle.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; FIFO_LEVEL_o ranges 0..FIFO_DEPTH.
REQ-027 RX_VALID_i during a push cycle is captured normally, with no byte loss.

Reset
REQ-028 On RST_IN high, asynchronously:
  - FSM goes to BYTE0; tick counter and FIFO pointers go to 0.
  - DAC_DATA_o = 18'd0; DAC_LOAD_o, FRAME_ERR_o, UNDERRUN_o and OVERRUN_o = 0; FIFO_LEVEL_o = 0.
REQ-029 Reset mid-frame discards the partial frame; reset mid-load cancels the strobe.
REQ-030 Sticky flags clear only on reset.

Configuration
REQ-031 Macro SEQ_TIMEOUT_EN defined: in BYTE1/BYTE2, a gap of TIMEOUT_CYCLES cycles with no RX_VALID_i returns the FSM to BYTE0, discards the partial frame and pulses FRAME_ERR_o.
REQ-032 The gap counter restarts on every RX_VALID_i.
REQ-033 Macro SEQ_TIMEOUT_EN undefined: no timeout logic is built; a partial frame persists indefinitely.

Verification
REQ-034 Bytes B8,01,00 -> FIFO_LEVEL_o = 1; next tick -> DAC_LOAD_o one cycle later with DAC_DATA_o = 18'h001B8 (440).
REQ-035 Frames 261, 293, 329 back-to-back -> loads on three consecutive ticks, each 272 cycles apart, values 0x105, 0x125, 0x149 in order.
REQ-036 9 frames with ticks blocked (DAC_READY_i = 0) -> level 8, OVERRUN_o = 1, first 8 samples played in order afterwards.
REQ-037 Bytes 5D,01,04 -> FRAME_ERR_o pulse, level unchanged; following frame 5D,01,00 plays as 0x15D (349).
REQ-038 With SEQ_TIMEOUT_EN: bytes 87,01 then a 5000-cycle gap -> FRAME_ERR_o pulse; then 87,01,00 -> sample 0x187 (391). Empty FIFO at a tick -> UNDERRUN_o = 1 and DAC_DATA_o held.
